// File: rtl/dmem_mmio_sys.sv
// Data-memory subsystem for the single-cycle RV32I core: byte-lane RAM with
// combinational reads, plus a 16-byte MMIO window (cycle counter, GPIO, TOHOST).
module dmem_mmio_sys #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int unsigned GPIO_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [2:0]        size,
  input  logic [31:0]       a,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic              misaligned,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              halted,
  output logic [31:0]       halt_code
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } sz_e;

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [63:0]       cnt_q, cnt_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic              halted_q, halted_d;
  logic [31:0]       halt_code_q, halt_code_d;

  sz_e               sz_s;
  logic              sext_s;
  logic              ram_hit_s;
  logic              mmio_hit_s;
  logic              misaligned_s;
  logic [AW-1:0]     idx_s;
  logic [31:0]       word_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [31:0]       ram_rd_s;
  logic [31:0]       mmio_rd_s;
  logic [31:0]       rd_s;
  logic              wr_ok_s;
  logic              ram_we_s;
  logic              gpio_we_s;
  logic              host_we_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;

  // Access decode: size class, region hit and legality.
  always_comb begin
    sz_s   = SZ_BAD;
    sext_s = 1'b0;
    case (size)
      3'b000: begin sz_s = SZ_B; sext_s = 1'b1; end
      3'b001: begin sz_s = SZ_H; sext_s = 1'b1; end
      3'b010: begin sz_s = SZ_W; sext_s = 1'b0; end
      3'b100: begin sz_s = SZ_B; sext_s = 1'b0; end
      3'b101: begin sz_s = SZ_H; sext_s = 1'b0; end
      default: begin sz_s = SZ_BAD; sext_s = 1'b0; end
    endcase

    // RAM_BASE is aligned to the RAM size, so a tag compare is an exact range check.
    ram_hit_s  = (a[31:AW+2] == RAM_BASE[31:AW+2]);
    mmio_hit_s = (a[31:4] == MMIO_BASE[31:4]);
    idx_s      = a[AW+1:2];

    if (ram_hit_s || mmio_hit_s) begin
      misaligned_s = (sz_s == SZ_BAD)
                  || ((sz_s == SZ_H) && a[0])
                  || ((sz_s == SZ_W) && (a[1:0] != 2'b00))
                  || (mmio_hit_s && (size != 3'b010));
    end else begin
      misaligned_s = 1'b0;
    end
  end

  // Combinational load path with lane select and extension.
  always_comb begin
    word_s = mem_q[idx_s];
    case (a[1:0])
      2'b00:   byte_s = word_s[7:0];
      2'b01:   byte_s = word_s[15:8];
      2'b10:   byte_s = word_s[23:16];
      2'b11:   byte_s = word_s[31:24];
      default: byte_s = 8'h00;
    endcase
    if (a[1]) begin
      half_s = word_s[31:16];
    end else begin
      half_s = word_s[15:0];
    end

    case (sz_s)
      SZ_B:    ram_rd_s = {{24{sext_s & byte_s[7]}}, byte_s};
      SZ_H:    ram_rd_s = {{16{sext_s & half_s[15]}}, half_s};
      SZ_W:    ram_rd_s = word_s;
      default: ram_rd_s = 32'h0000_0000;
    endcase

    case (a[3:2])
      2'b00:   mmio_rd_s = cnt_q[31:0];
      2'b01:   mmio_rd_s = cnt_q[63:32];
      2'b10:   mmio_rd_s = 32'(gpio_q);
      2'b11:   mmio_rd_s = 32'h0000_0000;
      default: mmio_rd_s = 32'h0000_0000;
    endcase

    if (misaligned_s) begin
      rd_s = 32'h0000_0000;
    end else if (ram_hit_s) begin
      rd_s = ram_rd_s;
    end else if (mmio_hit_s) begin
      rd_s = mmio_rd_s;
    end else begin
      rd_s = 32'h0000_0000;
    end
  end

  // Store path: write qualification, byte enables and lane-replicated data.
  always_comb begin
    wr_ok_s   = we && !misaligned_s && !halted_q && !rst;
    ram_we_s  = wr_ok_s && ram_hit_s;
    gpio_we_s = wr_ok_s && mmio_hit_s && (a[3:2] == 2'b10);
    host_we_s = wr_ok_s && mmio_hit_s && (a[3:2] == 2'b11);

    case (sz_s)
      SZ_B: begin
        be_s    = 4'b0001 << a[1:0];
        wdata_s = {4{wd[7:0]}};
      end
      SZ_H: begin
        be_s    = a[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{wd[15:0]}};
      end
      SZ_W: begin
        be_s    = 4'b1111;
        wdata_s = wd;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Next-state for counter, GPIO and halt registers.
  always_comb begin
    if (halted_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 64'd1;
    end

    if (gpio_we_s) begin
      gpio_d = wd[GPIO_W-1:0];
    end else begin
      gpio_d = gpio_q;
    end

    // A zero write to TOHOST is a no-op so software can clear its own value safely.
    if (host_we_s && (wd != 32'h0000_0000)) begin
      halted_d    = 1'b1;
      halt_code_d = wd;
    end else begin
      halted_d    = halted_q;
      halt_code_d = halt_code_q;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 64'd0;
      gpio_q      <= '0;
      halted_q    <= 1'b0;
      halt_code_q <= 32'h0000_0000;
    end else begin
      cnt_q       <= cnt_d;
      gpio_q      <= gpio_d;
      halted_q    <= halted_d;
      halt_code_q <= halt_code_d;
    end
  end

  // RAM byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we_s && be_s[b]) begin
        mem_q[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
      end
    end
  end

  assign rd         = rd_s;
  assign misaligned = misaligned_s;
  assign gpio_out   = gpio_q;
  assign halted     = halted_q;
  assign halt_code  = halt_code_q;

endmodule
